// File: rtl/exec_stage_param_if.sv
// exec_stage_param_if: decode-to-execute inputs and execute-to-memory outputs of the execute stage
interface exec_stage_param_if #(
  parameter int DATA_W = 8,
  parameter int OP_W = 5,
  parameter int RW_W = 5
);
  logic valid_dec;
  logic [OP_W-1:0] op_dec;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [DATA_W-1:0] data_in;
  logic [RW_W-1:0] RW_dec;
  logic mem_en_dec;
  logic mem_rw_dec;
  logic mem_mux_sel_dec;
  logic stall;
  logic valid_ex;
  logic [DATA_W-1:0] ans_ex;
  logic [DATA_W-1:0] ans_hi_ex;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] B_Bypass;
  logic [3:0] flag_ex;
  logic [RW_W-1:0] RW_ex;
  logic mem_en_ex;
  logic mem_rw_ex;
  logic mem_mux_sel_ex;
  modport master (
    output valid_dec, op_dec, A, B, data_in, RW_dec, mem_en_dec, mem_rw_dec, mem_mux_sel_dec,
    input stall, valid_ex, ans_ex, ans_hi_ex, data_out, B_Bypass, flag_ex, RW_ex,
          mem_en_ex, mem_rw_ex, mem_mux_sel_ex
  );
  modport slave (
    input valid_dec, op_dec, A, B, data_in, RW_dec, mem_en_dec, mem_rw_dec, mem_mux_sel_dec,
    output stall, valid_ex, ans_ex, ans_hi_ex, data_out, B_Bypass, flag_ex, RW_ex,
           mem_en_ex, mem_rw_ex, mem_mux_sel_ex
  );
endinterface

// File: rtl/exec_stage_param.sv
// exec_stage_param: execute stage with single-cycle ALU/shift/memory ops and iterative MUL/DIV
module exec_stage_param #(
  parameter int DATA_W = 8,
  parameter int OP_W = 5,
  parameter int RW_W = 5,
  parameter int SH_W = $clog2(DATA_W)
) (
  input logic clk,
  input logic reset,
  exec_stage_param_if.slave bus
);
  localparam logic [OP_W-1:0] OP_ADD = 'b00000, OP_SUB = 'b00001, OP_MOV = 'b00010,
    OP_AND = 'b00100, OP_OR = 'b00101, OP_XOR = 'b00110, OP_NOT = 'b00111,
    OP_SLL = 'b11001, OP_SRL = 'b11010, OP_SRA = 'b11011, OP_LOAD = 'b10110,
    OP_STORE = 'b10111, OP_PA0 = 'b10100, OP_PA1 = 'b10101, OP_MUL = 'b10010, OP_DIV = 'b10011;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] acc, q, m, bx, res, mul_lo, mul_hi, div_lo, div_hi, it_lo, it_hi, dsub;
  logic [DATA_W:0] sum, ms, r;
  logic [SH_W-1:0] cnt, sh;
  logic [RW_W-1:0] cap_rw;
  logic cap_en, cap_rw_m, cap_mux, is_div, sub, cin, arith, upd_fl, multi, ge;
  logic [3:0] flg, it_flg;
  assign sub = bus.op_dec == OP_SUB;
  assign multi = bus.op_dec == OP_MUL || bus.op_dec == OP_DIV;
  assign sh = bus.B[SH_W-1:0];
  assign bx = sub ? ~bus.B : bus.B;
  assign sum = {1'b0, bus.A} + {1'b0, bx} + {{DATA_W{1'b0}}, sub};
  assign cin = sum[DATA_W-1] ^ bus.A[DATA_W-1] ^ bx[DATA_W-1];
  // Single-cycle result selection; ops that hold ans_ex fall through to the held value
  always_comb begin
    res = bus.ans_ex;
    upd_fl = 1'b1;
    arith = 1'b0;
    case (bus.op_dec)
      OP_ADD, OP_SUB: begin res = sum[DATA_W-1:0]; arith = 1'b1; end
      OP_MOV: res = bus.B;
      OP_AND: res = bus.A & bus.B;
      OP_OR: res = bus.A | bus.B;
      OP_XOR: res = bus.A ^ bus.B;
      OP_NOT: res = ~bus.B;
      OP_SLL: res = bus.A << sh;
      OP_SRL: res = bus.A >> sh;
      OP_SRA: res = $unsigned($signed(bus.A) >>> sh);
      OP_LOAD: res = bus.data_in;
      OP_PA0, OP_PA1: begin res = bus.A; upd_fl = 1'b0; end
      default: upd_fl = 1'b0;
    endcase
  end
  assign flg = upd_fl ? {^res, arith & (cin ^ sum[DATA_W]), res == '0, arith & sum[DATA_W]} : bus.flag_ex;
  // One shift-add multiply step: {acc,q} holds the partial product, q's LSB selects the add
  assign ms = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
  assign mul_hi = ms[DATA_W:1];
  assign mul_lo = {ms[0], q[DATA_W-1:1]};
  // One restoring divide step: acc is the partial remainder, q shifts dividend out and quotient in
  assign r = {acc, q[DATA_W-1]};
  assign ge = r >= {1'b0, m};
  assign dsub = r[DATA_W-1:0] - m;
  assign div_hi = ge ? dsub : r[DATA_W-1:0];
  assign div_lo = {q[DATA_W-2:0], ge};
  assign it_lo = is_div ? div_lo : mul_lo;
  assign it_hi = is_div ? div_hi : mul_hi;
  assign it_flg = {^it_lo, ~is_div & (it_hi != '0), it_lo == '0, is_div ? m == '0 : it_hi != '0};
  // State register
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // Next state: enter BUSY on an accepted MUL/DIV, leave after the last iteration
  always_comb
    state_nx = state == IDLE ? (bus.valid_dec && multi ? BUSY : IDLE) : (cnt == '0 ? IDLE : BUSY);
  // Stall depends on state only
  always_comb bus.stall = state == BUSY;
  // Datapath and output registers
  always_ff @(posedge clk)
    if (!reset) begin
      {acc, q, m, cnt, cap_rw, cap_en, cap_rw_m, cap_mux, is_div} <= '0;
      {bus.valid_ex, bus.ans_ex, bus.ans_hi_ex, bus.data_out, bus.B_Bypass, bus.flag_ex} <= '0;
      {bus.RW_ex, bus.mem_en_ex, bus.mem_rw_ex, bus.mem_mux_sel_ex} <= '0;
    end else begin
      bus.valid_ex <= 1'b0;
      if (state == IDLE && bus.valid_dec && multi) begin
        acc <= '0;
        q <= bus.A;
        m <= bus.B;
        is_div <= bus.op_dec == OP_DIV;
        cnt <= SH_W'(DATA_W - 1);
        {cap_rw, cap_en, cap_rw_m, cap_mux} <= {bus.RW_dec, bus.mem_en_dec, bus.mem_rw_dec, bus.mem_mux_sel_dec};
      end else if (state == IDLE && bus.valid_dec) begin
        bus.valid_ex <= 1'b1;
        bus.ans_ex <= res;
        bus.flag_ex <= flg;
        bus.B_Bypass <= bus.B;
        if (bus.op_dec == OP_STORE) bus.data_out <= bus.A;
        {bus.RW_ex, bus.mem_en_ex, bus.mem_rw_ex, bus.mem_mux_sel_ex} <=
          {bus.RW_dec, bus.mem_en_dec, bus.mem_rw_dec, bus.mem_mux_sel_dec};
      end else if (state == BUSY) begin
        acc <= it_hi;
        q <= it_lo;
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          bus.valid_ex <= 1'b1;
          bus.ans_ex <= it_lo;
          bus.ans_hi_ex <= it_hi;
          bus.flag_ex <= it_flg;
          bus.B_Bypass <= m;
          {bus.RW_ex, bus.mem_en_ex, bus.mem_rw_ex, bus.mem_mux_sel_ex} <= {cap_rw, cap_en, cap_rw_m, cap_mux};
        end
      end
    end
endmodule

// File: tb/tb_exec_stage_param.sv
// tb_exec_stage_param: directed vectors with hand-computed results for the execute stage
module tb_exec_stage_param;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  logic seen;
  exec_stage_param_if #(.DATA_W(8), .OP_W(5), .RW_W(5)) bus ();
  exec_stage_param #(.DATA_W(8), .OP_W(5), .RW_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [4:0] op, input logic [7:0] a, input logic [7:0] b, input logic [4:0] rw);
    bus.valid_dec = v;
    bus.op_dec = op;
    bus.A = a;
    bus.B = b;
    bus.RW_dec = rw;
  endtask
  task automatic issue(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b, input logic [4:0] rw);
    drive(1'b1, op, a, b, rw);
    step();
    bus.valid_dec = 1'b0;
  endtask
  task automatic run_multi(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b, input logic [4:0] rw, output int n);
    drive(1'b1, op, a, b, rw);
    step();
    drive(1'b1, 5'b00000, ~a, 8'h00, ~rw);
    n = 0;
    while (bus.stall && n < 40) begin
      chk("valid_during_stall", 16'(bus.valid_ex), 16'h0);
      n++;
      step();
    end
    bus.valid_dec = 1'b0;
  endtask
  initial begin
    drive(1'b0, 5'b0, 8'h0, 8'h0, 5'h0);
    bus.data_in = 8'h0;
    {bus.mem_en_dec, bus.mem_rw_dec, bus.mem_mux_sel_dec} = 3'b000;
    step();
    step();
    chk("rst_ans", 16'(bus.ans_ex), 16'h0);
    chk("rst_hi", 16'(bus.ans_hi_ex), 16'h0);
    chk("rst_flag", 16'(bus.flag_ex), 16'h0);
    chk("rst_valid", 16'(bus.valid_ex), 16'h0);
    chk("rst_stall", 16'(bus.stall), 16'h0);
    chk("rst_misc", {bus.data_out, bus.B_Bypass}, 16'h0);
    reset = 1'b1;
    issue(5'b00000, 8'h7F, 8'h01, 5'd4);
    chk("add_ans", 16'(bus.ans_ex), 16'h80);
    chk("add_flag", 16'(bus.flag_ex), 16'hC);
    chk("add_valid", 16'(bus.valid_ex), 16'h1);
    chk("add_rw", 16'(bus.RW_ex), 16'd4);
    issue(5'b00001, 8'h05, 8'h05, 5'd5);
    chk("sub_ans", 16'(bus.ans_ex), 16'h00);
    chk("sub_flag", 16'(bus.flag_ex), 16'h3);
    step();
    chk("idle_valid", 16'(bus.valid_ex), 16'h0);
    chk("idle_ans", 16'(bus.ans_ex), 16'h00);
    chk("idle_flag", 16'(bus.flag_ex), 16'h3);
    issue(5'b01000, 8'h11, 8'h22, 5'd6);
    chk("nop_ans", 16'(bus.ans_ex), 16'h00);
    chk("nop_flag", 16'(bus.flag_ex), 16'h3);
    chk("nop_rw_bypass", {3'b0, bus.RW_ex, bus.B_Bypass}, {3'b0, 5'd6, 8'h22});
    bus.mem_en_dec = 1'b1;
    run_multi(5'b10010, 8'h12, 8'h10, 5'd9, cyc);
    bus.mem_en_dec = 1'b0;
    chk("mul_stall_cycles", 16'(cyc), 16'd8);
    chk("mul_valid", 16'(bus.valid_ex), 16'h1);
    chk("mul_lo", 16'(bus.ans_ex), 16'h20);
    chk("mul_hi", 16'(bus.ans_hi_ex), 16'h01);
    chk("mul_flag", 16'(bus.flag_ex), 16'hD);
    chk("mul_rw", 16'(bus.RW_ex), 16'd9);
    chk("mul_mem_en", 16'(bus.mem_en_ex), 16'h1);
    chk("mul_bypass", 16'(bus.B_Bypass), 16'h10);
    step();
    chk("mul_valid_drop", 16'(bus.valid_ex), 16'h0);
    run_multi(5'b10011, 8'h64, 8'h07, 5'd10, cyc);
    chk("div_cycles", 16'(cyc), 16'd8);
    chk("div_q", 16'(bus.ans_ex), 16'h0E);
    chk("div_r", 16'(bus.ans_hi_ex), 16'h02);
    chk("div_flag", 16'(bus.flag_ex), 16'h8);
    run_multi(5'b10011, 8'h33, 8'h00, 5'd11, cyc);
    chk("div0_cycles", 16'(cyc), 16'd8);
    chk("div0_q", 16'(bus.ans_ex), 16'hFF);
    chk("div0_r", 16'(bus.ans_hi_ex), 16'h33);
    chk("div0_flag", 16'(bus.flag_ex), 16'h1);
    issue(5'b11011, 8'h80, 8'h07, 5'd1);
    chk("sra_ans", 16'(bus.ans_ex), 16'hFF);
    chk("sra_flag", 16'(bus.flag_ex), 16'h0);
    issue(5'b11001, 8'h81, 8'h01, 5'd2);
    chk("sll_ans", 16'(bus.ans_ex), 16'h02);
    chk("sll_flag", 16'(bus.flag_ex), 16'h8);
    issue(5'b11010, 8'h81, 8'h03, 5'd2);
    chk("srl_ans", 16'(bus.ans_ex), 16'h10);
    issue(5'b10111, 8'h5A, 8'h00, 5'd3);
    chk("store_data", 16'(bus.data_out), 16'h5A);
    chk("store_ans", 16'(bus.ans_ex), 16'h10);
    chk("store_flag", 16'(bus.flag_ex), 16'h8);
    bus.data_in = 8'hC3;
    issue(5'b10110, 8'h00, 8'h00, 5'd7);
    chk("load_ans", 16'(bus.ans_ex), 16'hC3);
    chk("load_flag", 16'(bus.flag_ex), 16'h0);
    issue(5'b10100, 8'h00, 8'h00, 5'd7);
    chk("pass_ans", 16'(bus.ans_ex), 16'h00);
    chk("pass_flag", 16'(bus.flag_ex), 16'h0);
    issue(5'b10010, 8'h12, 8'h10, 5'd9);
    chk("abort_stall", 16'(bus.stall), 16'h1);
    step();
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("abort_stall_low", 16'(bus.stall), 16'h0);
    chk("abort_valid", 16'(bus.valid_ex), 16'h0);
    chk("abort_outs", {bus.ans_ex, bus.ans_hi_ex}, 16'h0);
    chk("abort_flag_rw", {7'b0, bus.flag_ex, bus.RW_ex}, 16'h0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      seen = seen | bus.valid_ex | bus.stall;
    end
    chk("abort_no_valid", 16'(seen), 16'h0);
    issue(5'b00000, 8'h03, 8'h04, 5'd12);
    chk("post_add_ans", 16'(bus.ans_ex), 16'h07);
    chk("post_add_flag", 16'(bus.flag_ex), 16'h8);
    chk("post_add_valid", 16'(bus.valid_ex), 16'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/exec_stage_param.md
Name: exec_stage_param

Overview:
- Parametrised next-generation execute stage for the pipelined core: ALU, shifter, load/store pass-through and flag generation at configurable data width.
- Adds multi-cycle iterative multiply and divide, with a stall handshake back to decode.
- Sits between decode and memory stages; registers the result, flags and memory/write-back sideband toward the memory stage.

Parameters:
- DATA_W, 8, operand/result width (≥4, power of two)
- OP_W, 5, opcode width
- RW_W, 5, write-back register address width
- SH_W, $clog2(DATA_W), shift-amount bits taken from B[SH_W-1:0]

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous active-low reset
- valid_dec  in  1  decode presents an instruction this cycle
- op_dec  in  OP_W  opcode
- A, B  in  DATA_W  operands
- data_in  in  DATA_W  load data
- RW_dec  in  RW_W  destination register
- mem_en_dec, mem_rw_dec, mem_mux_sel_dec  in  1 each  memory sideband
- stall  out  1  execute busy; decode must hold all inputs stable
- valid_ex  out  1  registered outputs carry a new result
- ans_ex, ans_hi_ex  out  DATA_W  result / high half (MUL) or remainder (DIV)
- data_out, B_Bypass  out  DATA_W  store data (A on STORE, else held) / registered B
- flag_ex  out  4  registered {parity, overflow, zero, carry}
- RW_ex  out  RW_W  registered destination
- mem_en_ex, mem_rw_ex, mem_mux_sel_ex  out  1 each  registered sideband

Behaviour:
- Clocking and reset:
  - Single clock clk.
  - reset is synchronous, active-low: at an edge with reset=0, every output and internal register goes to 0, the FSM goes to IDLE and the counter to 0. A reset mid-BUSY aborts the operation; no valid_ex is produced for it.
- Opcodes:
  - 00000 ADD, 00001 SUB (A+~B+1), 00010 MOV B, 00100 AND, 00101 OR, 00110 XOR, 00111 NOT B.
  - 11001 SLL, 11010 SRL, 11011 SRA by B[SH_W-1:0]; SRA sign-fills for all amounts 0..DATA_W-1.
  - 10110 LOAD (ans=data_in), 10111 STORE (data_out=A, ans held), 10100/10101 pass A (flags held).
  - 10010 MUL (unsigned; low half→ans_ex, high half→ans_hi_ex).
  - 10011 DIV (unsigned restoring; quotient→ans_ex, remainder→ans_hi_ex).
  - Any other opcode: NOP — ans_ex and flags held, sideband still registered.
- Flags:
  - parity = XOR of ans bits; zero = ans==0.
  - ADD/SUB: carry = carry-out of MSB; overflow = carry-in XOR carry-out of MSB.
  - Logic/shift/MOV/LOAD: overflow=0, carry=0.
  - MUL: carry = overflow = (high half ≠ 0).
  - DIV: overflow=0, carry=1 only on divide-by-zero.
  - STORE/pass/NOP: flags held.
- FSM IDLE:
  - When valid_dec=1 with a single-cycle op, outputs are registered at that edge; valid_ex=1 the next cycle (latency 1).
  - When valid_dec=1 with MUL/DIV: operands and sideband are captured, counter loads DATA_W-1, state goes to BUSY, valid_ex=0.
  - When valid_dec=0: valid_ex=0, all other outputs held.
- FSM BUSY:
  - stall=1 for the whole state; op_dec and valid_dec are ignored.
  - One shift-add / restoring-subtract iteration per edge; counter decrements.
  - At the edge where counter==0: results, flags and captured sideband are written, valid_ex=1, state returns to IDLE, stall drops.
  - Result: stall high exactly DATA_W cycles; valid_ex asserted in cycle DATA_W+1 after acceptance.
- Divide-by-zero: no iterations are skipped (fixed latency); quotient = all ones, remainder = A, carry=1.
- stall is combinational from state only (state==BUSY); there is no combinational path from inputs to stall.
- B_Bypass, RW_ex and mem_* outputs update together with ans_ex and valid_ex, never earlier.

Test Plan:
- DATA_W=8, reset=0 for 2 edges then 1 → all outputs 0, stall=0; ADD 0x7F+0x01 → next cycle ans_ex=0x80, flag_ex=4'b1100, valid_ex=1.
- SUB 0x05-0x05 → ans_ex=0x00, flag_ex=4'b0011; then NOP → ans_ex/flag_ex held, valid_ex=0 if valid_dec=0.
- MUL 0x12×0x10 → stall=1 for 8 cycles, then ans_ex=0x20, ans_hi_ex=0x01, flag_ex=4'b1101, RW_ex=captured RW_dec; input changes during stall ignored.
- DIV 0x64/0x07 → ans_ex=0x0E, ans_hi_ex=0x02, flag_ex=4'b1000; DIV 0x33/0x00 → ans_ex=0xFF, ans_hi_ex=0x33, carry=1, same 8-cycle latency.
- SRA 0x80 by 7 → 0xFF, flag_ex=4'b0000; SLL 0x81 by 1 → 0x02; STORE A=0x5A → data_out=0x5A, flags unchanged.
- Reset=0 at 4th BUSY cycle of MUL → next cycle all outputs 0, stall=0, no valid_ex; following ADD completes normally with latency 1.
